bpm2per: RTL and testbench

BPM2PER -- requirements
Module: bpm2per

---
 rtl/bpm2per.sv | 163 ++++++++++++++++
 tb/tb_bpm2per.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bpm2per.sv
// BPM to beat-period converter: per_o = floor((MIN_NS/PULSE_PER_NS) / bpm_i) via a 24-step restoring divider.
// Optional macro BPM2PER_SAT_FLAG_EN adds the sat_o flag output.
module bpm2per #(
  parameter int unsigned     PULSE_PER_NS = 32'd5120,
  parameter int unsigned     BPMPER_MAX   = 32'd62600,
  parameter int unsigned     BPM_MAX      = 32'd250,
  parameter longint unsigned MIN_NS       = 64'd60_000_000_000,
  localparam int             BW           = $clog2(BPM_MAX + 1),
  localparam int             PW           = $clog2(BPMPER_MAX + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [BW-1:0] bpm_i,
  input  logic          bpm_valid_i,
  output logic [PW-1:0] per_o,
  output logic          per_valid_o,
  output logic          busy_o
`ifdef BPM2PER_SAT_FLAG_EN
  ,
  output logic          sat_o
`endif
);

  localparam logic [23:0]   DIVIDEND  = 24'(MIN_NS / 64'(PULSE_PER_NS));
  localparam logic [23:0]   PER_MAX_Q = 24'(BPMPER_MAX);
  localparam logic [PW-1:0] PER_MAX_O = PW'(BPMPER_MAX);
  localparam logic [BW-1:0] BPM_MAX_B = BW'(BPM_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic          rst_ok_q;
  logic [7:0]    div_q, div_d;
  logic [23:0]   quo_q, quo_d;
  logic [8:0]    rem_q, rem_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          zero_q, zero_d;
  logic [PW-1:0] per_q, per_d;
  logic          per_valid_q, per_valid_d;
  logic          busy_q, busy_d;
`ifdef BPM2PER_SAT_FLAG_EN
  logic          clamp_q, clamp_d;
  logic          sat_q, sat_d;
`endif

  logic          accept_s;
  logic [BW-1:0] bpm_clamped_s;
  logic [9:0]    trial_s;
  logic [9:0]    diff_s;

  // rst_ok_q blocks acceptance on the first edge after reset release
  assign accept_s      = (state_q == IDLE) && bpm_valid_i && rst_ok_q;
  assign bpm_clamped_s = (bpm_i > BPM_MAX_B) ? BPM_MAX_B : bpm_i;
  // Quotient register doubles as the dividend shifter; diff_s[9] is the borrow
  assign trial_s       = {rem_q, quo_q[23]};
  assign diff_s        = trial_s - {2'b00, div_q};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      rst_ok_q    <= 1'b0;
      div_q       <= 8'd0;
      quo_q       <= 24'd0;
      rem_q       <= 9'd0;
      cnt_q       <= 5'd0;
      zero_q      <= 1'b0;
      per_q       <= {PW{1'b0}};
      per_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef BPM2PER_SAT_FLAG_EN
      clamp_q     <= 1'b0;
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rst_ok_q    <= 1'b1;
      div_q       <= div_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      zero_q      <= zero_d;
      per_q       <= per_d;
      per_valid_q <= per_valid_d;
      busy_q      <= busy_d;
`ifdef BPM2PER_SAT_FLAG_EN
      clamp_q     <= clamp_d;
      sat_q       <= sat_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = CALC;
        else          state_d = IDLE;
      end
      CALC: begin
        if (cnt_q == 5'd23) state_d = DONE;
        else                state_d = CALC;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d       = div_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    zero_d      = zero_q;
    per_d       = per_q;
    per_valid_d = 1'b0;
    busy_d      = (state_d != IDLE);
`ifdef BPM2PER_SAT_FLAG_EN
    clamp_d     = clamp_q;
    sat_d       = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          div_d  = 8'(bpm_clamped_s);
          quo_d  = DIVIDEND;
          rem_d  = 9'd0;
          cnt_d  = 5'd0;
          zero_d = (bpm_i == {BW{1'b0}});
`ifdef BPM2PER_SAT_FLAG_EN
          clamp_d = (bpm_i > BPM_MAX_B);
`endif
        end else begin
          cnt_d = cnt_q;
        end
      end
      CALC: begin
        quo_d = {quo_q[22:0], ~diff_s[9]};
        rem_d = diff_s[9] ? trial_s[8:0] : diff_s[8:0];
        cnt_d = cnt_q + 5'd1;
      end
      DONE: begin
        per_valid_d = 1'b1;
        // Saturate in 24-bit space so large quotients never wrap into 16 bits
        if (zero_q || (quo_q > PER_MAX_Q)) per_d = PER_MAX_O;
        else                               per_d = PW'(quo_q);
`ifdef BPM2PER_SAT_FLAG_EN
        sat_d = zero_q | clamp_q | (quo_q > PER_MAX_Q);
`endif
      end
      default: begin
        per_valid_d = 1'b0;
      end
    endcase
  end

  assign per_o       = per_q;
  assign per_valid_o = per_valid_q;
  assign busy_o      = busy_q;
`ifdef BPM2PER_SAT_FLAG_EN
  assign sat_o       = sat_q;
`endif

endmodule

// File: tb/tb_bpm2per.sv
// Self-checking bench for bpm2per: vector table, random requests vs arithmetic model, corner sequences.
module tb_bpm2per;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  bpm;
  logic        bv;
  logic [15:0] per_o;
  logic        per_valid_o;
  logic        busy_o;
`ifdef BPM2PER_SAT_FLAG_EN
  logic        sat_o;
`endif

  int checks = 0;
  int errors = 0;

  bpm2per dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .bpm_i       (bpm),
    .bpm_valid_i (bv),
    .per_o       (per_o),
    .per_valid_o (per_valid_o),
    .busy_o      (busy_o)
`ifdef BPM2PER_SAT_FLAG_EN
    ,
    .sat_o       (sat_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int bpm;
    int per;
    bit sat;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: period = floor(60e9/5120 / min(bpm,250)), saturated at 62600; bpm 0 -> 62600.
  function automatic void model(input int b, output int p, output bit s);
    longint d;
    longint q;
    int     e;
    d = 64'd60_000_000_000 / 64'd5120;
    e = (b > 250) ? 250 : b;
    if (b == 0) begin
      p = 62600;
      s = 1'b1;
    end else begin
      q = d / e;
      s = (b > 250) || (q > 62600);
      p = (q > 62600) ? 62600 : int'(q);
    end
  endfunction

  task automatic run_req(input int b, input int ep, input bit es, input string nm);
    int k;
    int bc;
    bpm = 8'(b);
    bv  = 1'b1;
    tick();
    bv  = 1'b0;
    bpm = 8'($urandom);
    bc  = busy_o ? 1 : 0;
    k   = 0;
    while (!per_valid_o && k < 40) begin
      tick();
      k++;
      if (busy_o) bc++;
    end
    chk({nm, " latency"}, k, 25);
    chk({nm, " busy cycles"}, bc, 25);
    chk({nm, " per"}, per_o, ep);
`ifdef BPM2PER_SAT_FLAG_EN
    chk({nm, " sat"}, sat_o, es);
`else
    if (es) k = k;
`endif
    tick();
    chk({nm, " pulse width"}, per_valid_o, 0);
    repeat (2) tick();
    chk({nm, " hold"}, per_o, ep);
  endtask

  initial begin
    int p;
    bit s;
    int pulses;
    int pc;
    int last;

    tbl[0] = '{250, 46875, 1'b0};
    tbl[1] = '{200, 58593, 1'b0};
    tbl[2] = '{188, 62333, 1'b0};
    tbl[3] = '{0,   62600, 1'b1};
    tbl[4] = '{100, 62600, 1'b1};
    tbl[5] = '{255, 46875, 1'b1};
    tbl[6] = '{187, 62600, 1'b1};
    tbl[7] = '{125, 62600, 1'b1};
    tbl[8] = '{240, 48828, 1'b0};

    rst_n = 1'b0;
    bv    = 1'b0;
    bpm   = 8'd0;
    repeat (3) tick();
    chk("reset per", per_o, 0);
    chk("reset valid", per_valid_o, 0);
    chk("reset busy", busy_o, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 9; i++)
      run_req(tbl[i].bpm, tbl[i].per, tbl[i].sat, $sformatf("vec%0d", i));

    for (int i = 0; i < 25; i++) begin
      int b;
      b = $urandom_range(0, 255);
      model(b, p, s);
      run_req(b, p, s, $sformatf("rand%0d bpm=%0d", i, b));
    end

    // Requests at cycles 5 and 25 after acceptance are dropped
    bpm = 8'd250;
    bv  = 1'b1;
    tick();
    pulses = 0;
    pc = -1;
    for (int c = 1; c <= 60; c++) begin
      bv  = (c == 5) || (c == 25);
      bpm = bv ? 8'd200 : 8'd0;
      tick();
      if (per_valid_o) begin
        pulses++;
        pc = c;
        chk("busy-drop per", per_o, 46875);
      end
    end
    bv = 1'b0;
    chk("busy-drop pulses", pulses, 1);
    chk("busy-drop pulse cycle", pc, 25);

    // Reset mid-CALC aborts the request
    bpm = 8'd200;
    bv  = 1'b1;
    tick();
    bv = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst per", per_o, 0);
    chk("midrst valid", per_valid_o, 0);
    chk("midrst busy", busy_o, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (per_valid_o) pulses++;
    end
    chk("midrst no pulse", pulses, 0);
    chk("midrst per held", per_o, 0);
    run_req(250, 46875, 1'b0, "post-reset");

    // Back-to-back with valid held high
    bpm = 8'd250;
    bv  = 1'b1;
    pulses = 0;
    last = -1;
    for (int c = 1; c <= 200 && pulses < 4; c++) begin
      tick();
      if (per_valid_o) begin
        pulses++;
        chk("b2b per", per_o, 46875);
        if (last >= 0) chk("b2b interval", c - last, 26);
        else           chk("b2b first", c, 26);
        last = c;
      end
    end
    bv = 1'b0;
    chk("b2b pulse count", pulses, 4);
    repeat (30) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
